// File: rtl/bridge_pkg.sv
// Shared types and default constants for the system bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_WAIT = 2'd1,
        BR_DONE = 2'd2
    } br_state_e;

    localparam int          HWINT_W           = 6;
    localparam logic [5:0]  MASK_RST          = 6'h3F;
    localparam logic [31:0] DEF_DEV_BASE      = 32'h0000_7F00;
    localparam logic [31:0] DEF_DEV_STRIDE    = 32'h0000_0010;
    localparam logic [31:0] DEF_DM_LIMIT      = 32'h0000_2FFF;
    localparam logic [31:0] DEF_IRQ_ACK_ADDR  = 32'h0000_7F40;
    localparam logic [31:0] DEF_IRQ_MASK_ADDR = 32'h0000_7F44;

endpackage

// File: rtl/bridge_access_fsm.sv
// Device access sequencer: start pulse, ready/timeout wait, one DONE cycle
// that presents the captured read data.
module bridge_access_fsm
    import bridge_pkg::*;
#(
    parameter int N_DEV   = 2,
    parameter int TIMEOUT = 15,
    parameter int IDX_W   = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               start_we_i,
    input  logic [IDX_W-1:0]   start_idx_i,
    input  logic [32*N_DEV-1:0] dev_rdata_i,
    input  logic [N_DEV-1:0]   dev_ready_i,
    output logic               idle_o,
    output logic               wait_o,
    output logic               done_o,
    output logic [N_DEV-1:0]   dev_we_o,
    output logic [N_DEV-1:0]   dev_re_o,
    output logic [31:0]        rdata_o,
    output logic               to_err_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    br_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        rdata_q;
    logic [N_DEV-1:0]   we_q, re_q;
    logic [31:0]        rd_sel;
    logic               rdy_sel;

    // Select the ready/data lane of the device latched at start.
    always_comb begin
        rd_sel  = '0;
        rdy_sel = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_sel  = dev_rdata_i[i*32 +: 32];
                rdy_sel = dev_ready_i[i];
            end
        end
    end

    // Timeout fires in the last WAIT cycle so bus_err is set as DONE begins.
    assign to_err_o = (state_q == BR_WAIT) && !rdy_sel && (cnt_q == CNT_W'(TIMEOUT));

    // Access sequencer; start pulses are registered and last exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BR_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            we_q    <= '0;
            re_q    <= '0;
        end else begin
            we_q <= '0;
            re_q <= '0;
            case (state_q)
                BR_IDLE: if (start_i) begin
                    state_q <= BR_WAIT;
                    cnt_q   <= '0;
                    idx_q   <= start_idx_i;
                    if (start_we_i) we_q <= N_DEV'(1) << start_idx_i;
                    else            re_q <= N_DEV'(1) << start_idx_i;
                end
                BR_WAIT: begin
                    if (rdy_sel) begin
                        rdata_q <= rd_sel;
                        state_q <= BR_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        rdata_q <= '0;
                        state_q <= BR_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BR_DONE: state_q <= BR_IDLE;
                default: state_q <= BR_IDLE;
            endcase
        end
    end

    assign idle_o   = (state_q == BR_IDLE);
    assign wait_o   = (state_q == BR_WAIT);
    assign done_o   = (state_q == BR_DONE);
    assign dev_we_o = we_q;
    assign dev_re_o = re_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/sys_bridge_n.sv
// CPU data-port bridge: DM passthrough, N_DEV device windows with a stalling
// handshake, and the masked interrupt-pending unit feeding hwint.
module sys_bridge_n
    import bridge_pkg::*;
#(
    parameter int          N_DEV         = 2,
    parameter logic [31:0] DEV_BASE      = DEF_DEV_BASE,
    parameter logic [31:0] DEV_STRIDE    = DEF_DEV_STRIDE,
    parameter int          DEV_SPAN      = 12,
    parameter logic [31:0] DM_LIMIT      = DEF_DM_LIMIT,
    parameter logic [31:0] IRQ_ACK_ADDR  = DEF_IRQ_ACK_ADDR,
    parameter logic [31:0] IRQ_MASK_ADDR = DEF_IRQ_MASK_ADDR,
    parameter int          TIMEOUT       = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [3:0]          cpu_byteen,
    input  logic                cpu_rd,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_stall,
    input  logic                req,
    output logic [31:0]         m_data_addr,
    output logic [31:0]         m_data_wdata,
    output logic [3:0]          m_data_byteen,
    input  logic [31:0]         m_data_rdata,
    output logic [31:0]         dev_addr,
    output logic [31:0]         dev_wdata,
    output logic [N_DEV-1:0]    dev_we,
    output logic [N_DEV-1:0]    dev_re,
    input  logic [32*N_DEV-1:0] dev_rdata,
    input  logic [N_DEV-1:0]    dev_ready,
    input  logic [N_DEV-1:0]    dev_irq,
    input  logic                ext_irq,
    output logic [HWINT_W-1:0]  hwint,
    output logic                bus_err
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    logic             dev_hit, hit_mask, hit_ack, hit_dm;
    logic [IDX_W-1:0] hit_idx;
    logic [31:0]      hit_off;
    logic             full_wr, part_wr, start;
    logic             f_idle, f_wait, f_done, to_err;
    logic [31:0]      f_rdata;
    logic             ext_q, ext_d, pend_q, pend_d, err_q, err_d;
    logic [5:0]       mask_q, mask_d;

    function automatic logic [31:0] win_base(input int i);
        return DEV_BASE + DEV_STRIDE * 32'(i);
    endfunction

    // Window decode; scanning downward lets the lowest index win an overlap.
    always_comb begin
        dev_hit = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (cpu_addr >= win_base(i) && cpu_addr < win_base(i) + 32'(DEV_SPAN)) begin
                dev_hit = 1'b1;
                hit_idx = IDX_W'(i);
                hit_off = cpu_addr - win_base(i);
            end
        end
    end

    assign hit_mask = !dev_hit && (cpu_addr == IRQ_MASK_ADDR);
    assign hit_ack  = !dev_hit && (cpu_addr == IRQ_ACK_ADDR);
    assign hit_dm   = !dev_hit && !hit_mask && !hit_ack && (cpu_addr <= DM_LIMIT);
    assign full_wr  = (cpu_byteen == 4'hF) && !req;
    assign part_wr  = (cpu_byteen != 4'h0) && (cpu_byteen != 4'hF) && !req;
    assign start    = dev_hit && (cpu_rd || full_wr);

    bridge_access_fsm #(.N_DEV(N_DEV), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .start_we_i  (full_wr),
        .start_idx_i (hit_idx),
        .dev_rdata_i (dev_rdata),
        .dev_ready_i (dev_ready),
        .idle_o      (f_idle),
        .wait_o      (f_wait),
        .done_o      (f_done),
        .dev_we_o    (dev_we),
        .dev_re_o    (dev_re),
        .rdata_o     (f_rdata),
        .to_err_o    (to_err)
    );

    // Next state of mask, pending bit, edge detector and sticky error.
    always_comb begin
        ext_d  = ext_irq;
        mask_d = (hit_mask && full_wr) ? cpu_wdata[5:0] : mask_q;
        pend_d = pend_q;
        if (hit_ack && full_wr) pend_d = 1'b0;
        if (ext_irq && !ext_q)  pend_d = 1'b1;     // new edge beats a same-cycle ack
        err_d  = err_q | to_err | (dev_hit && part_wr);
    end

    // Interrupt and error state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_q  <= 1'b0;
            pend_q <= 1'b0;
            mask_q <= MASK_RST;
            err_q  <= 1'b0;
        end else begin
            ext_q  <= ext_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    // Read-data mux; DONE presents the captured device word.
    always_comb begin
        if (f_done)        cpu_rdata = f_rdata;
        else if (dev_hit)  cpu_rdata = '0;
        else if (hit_mask) cpu_rdata = {26'b0, mask_q};
        else if (hit_dm)   cpu_rdata = m_data_rdata;
        else               cpu_rdata = '0;
    end

    // Interrupt lines: device levels and the external pending bit, masked.
    always_comb begin
        hwint             = '0;
        hwint[N_DEV-1:0]  = dev_irq & mask_q[N_DEV-1:0];
        hwint[N_DEV]      = pend_q & mask_q[N_DEV];
    end

    // Stall gated by reset so an in-flight access releases the CPU at once.
    assign cpu_stall     = reset && (f_wait || (f_idle && start));
    assign m_data_addr   = cpu_addr;
    assign m_data_wdata  = cpu_wdata;
    assign m_data_byteen = (hit_dm && !req) ? cpu_byteen : 4'h0;
    assign dev_addr      = hit_off;
    assign dev_wdata     = cpu_wdata;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench for sys_bridge_n with default parameters.
module tb_sys_bridge_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, m_data_addr, m_data_wdata, m_data_rdata;
    logic [31:0] dev_addr, dev_wdata;
    logic [3:0]  cpu_byteen, m_data_byteen;
    logic        cpu_rd, cpu_stall, req, ext_irq, bus_err;
    logic [1:0]  dev_we, dev_re, dev_ready, dev_irq;
    logic [63:0] dev_rdata;
    logic [5:0]  hwint;

    int n_cmp = 0;
    int n_err = 0;
    int stalls, we_cyc, re_cyc;
    logic [1:0] we_seen, re_seen;

    always #5 clk = ~clk;

    sys_bridge_n dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteen(cpu_byteen), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .req(req), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
        .m_data_rdata(m_data_rdata), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_we(dev_we), .dev_re(dev_re), .dev_rdata(dev_rdata),
        .dev_ready(dev_ready), .dev_irq(dev_irq), .ext_irq(ext_irq),
        .hwint(hwint), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_byteen = 4'h0; cpu_rd = 1'b0; req = 1'b0;
    endtask

    // Inputs already applied; walk the access to its first non-stalled cycle.
    task automatic run_access();
        stalls = 0; we_cyc = 0; re_cyc = 0; we_seen = '0; re_seen = '0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (dev_we != 0) begin we_cyc++; we_seen |= dev_we; end
            if (dev_re != 0) begin re_cyc++; re_seen |= dev_re; end
            if (!cpu_stall) break;
            stalls++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; idle_bus();
        m_data_rdata = 32'h0; dev_rdata = 64'h0; dev_ready = 2'b00;
        dev_irq = 2'b00; ext_irq = 1'b0;
        repeat (2) tick();
        chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_we_re", {28'b0, dev_we, dev_re}, 32'h0);
        chk("rst_hwint", {26'b0, hwint}, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        cpu_addr = 32'h7F44; #1;
        chk("rst_mask", cpu_rdata, 32'h3F);
        idle_bus(); #1; reset = 1'b1;
        tick();

        // DM load / store passthrough
        cpu_addr = 32'h1000; cpu_rd = 1'b1; m_data_rdata = 32'hDEADBEEF; #1;
        chk("dm_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("dm_stall", {31'b0, cpu_stall}, 32'h0);
        cpu_rd = 1'b0; cpu_byteen = 4'hF; cpu_addr = 32'h200; #1;
        chk("dm_byteen", {28'b0, m_data_byteen}, 32'hF);
        cpu_addr = 32'h7F30; cpu_rd = 1'b1; #1;
        chk("unmapped_rd", cpu_rdata, 32'h0);
        chk("unmapped_be", {28'b0, m_data_byteen}, 32'h0);
        idle_bus(); tick();

        // dev1 write, ready high
        dev_ready = 2'b10;
        cpu_addr = 32'h7F14; cpu_wdata = 32'h5; cpu_byteen = 4'hF; #1;
        chk("d1w_addr", dev_addr, 32'h4);
        chk("d1w_wdata", dev_wdata, 32'h5);
        run_access();
        chk("d1w_stalls", stalls, 2);
        chk("d1w_we_cyc", we_cyc, 1);
        chk("d1w_we_val", {30'b0, we_seen}, 32'h2);
        chk("d1w_re_cyc", re_cyc, 0);
        idle_bus(); tick();

        // dev1 read, ready high, data in DONE
        dev_rdata = {32'hCAFE0001, 32'h11111111};
        cpu_addr = 32'h7F10; cpu_rd = 1'b1;
        run_access();
        chk("d1r_stalls", stalls, 2);
        chk("d1r_re_val", {30'b0, re_seen}, 32'h2);
        chk("d1r_rdata", cpu_rdata, 32'hCAFE0001);
        chk("d1r_bus_err", {31'b0, bus_err}, 32'h0);
        idle_bus(); tick();

        // dev0 read, never ready: timeout
        cpu_addr = 32'h7F08; cpu_rd = 1'b1; #1;
        chk("to_addr", dev_addr, 32'h8);
        run_access();
        chk("to_stalls", stalls, 17);
        chk("to_re_val", {30'b0, re_seen}, 32'h1);
        chk("to_rdata", cpu_rdata, 32'h0);
        chk("to_bus_err", {31'b0, bus_err}, 32'h1);
        idle_bus(); repeat (3) tick();
        chk("to_err_sticky", {31'b0, bus_err}, 32'h1);

        // req suppresses writes
        req = 1'b1; cpu_byteen = 4'hF; cpu_addr = 32'h200; #1;
        chk("req_dm_be", {28'b0, m_data_byteen}, 32'h0);
        cpu_addr = 32'h7F00; #1;
        chk("req_dev_stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        chk("req_dev_we", {30'b0, dev_we}, 32'h0);
        chk("req_dev_stall2", {31'b0, cpu_stall}, 32'h0);
        idle_bus(); tick();

        // external IRQ pending, mask, ack
        ext_irq = 1'b1; #1;
        chk("irq_pre", {31'b0, hwint[2]}, 32'h0);
        tick();
        chk("irq_set", {31'b0, hwint[2]}, 32'h1);
        ext_irq = 1'b0;
        cpu_addr = 32'h7F44; cpu_wdata = 32'h3B; cpu_byteen = 4'hF;
        tick();
        cpu_byteen = 4'h0; #1;
        chk("irq_masked", {31'b0, hwint[2]}, 32'h0);
        chk("mask_rd", cpu_rdata, 32'h3B);
        cpu_wdata = 32'h3F; cpu_byteen = 4'hF;
        tick();
        cpu_byteen = 4'h0; #1;
        chk("irq_unmasked", {31'b0, hwint[2]}, 32'h1);
        cpu_addr = 32'h7F40; cpu_byteen = 4'hF; #1;
        chk("ack_rd", cpu_rdata, 32'h0);
        tick();
        cpu_byteen = 4'h0; #1;
        chk("irq_acked", {31'b0, hwint[2]}, 32'h0);
        ext_irq = 1'b1; cpu_byteen = 4'hF;
        tick();
        cpu_byteen = 4'h0; ext_irq = 1'b0; #1;
        chk("ack_vs_edge", {31'b0, hwint[2]}, 32'h1);
        dev_irq = 2'b11; #1;
        chk("hwint_dev", {26'b0, hwint}, 32'h07);
        cpu_addr = 32'h7F44; cpu_wdata = 32'h06; cpu_byteen = 4'hF;
        tick();
        idle_bus(); #1;
        chk("hwint_mask06", {26'b0, hwint}, 32'h06);
        dev_irq = 2'b00;

        // reset during an access
        dev_ready = 2'b00;
        cpu_addr = 32'h7F00; cpu_rd = 1'b1;
        tick(); tick();
        chk("mid_stall_pre", {31'b0, cpu_stall}, 32'h1);
        reset = 1'b0; #1;
        chk("mid_stall_rst", {31'b0, cpu_stall}, 32'h0);
        chk("mid_bus_err", {31'b0, bus_err}, 32'h0);
        idle_bus(); #2; reset = 1'b1;
        tick();
        chk("mid_idle", {31'b0, cpu_stall}, 32'h0);

        // partial device store
        cpu_addr = 32'h7F00; cpu_byteen = 4'h1; cpu_wdata = 32'hAB; #1;
        chk("part_stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        chk("part_bus_err", {31'b0, bus_err}, 32'h1);
        chk("part_we", {30'b0, dev_we}, 32'h0);
        chk("part_stall2", {31'b0, cpu_stall}, 32'h0);
        idle_bus(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised system bridge between the CPU data port and the memory/peripheral space. It passes data-memory accesses straight through, decodes `N_DEV` stride-spaced device windows, and runs a stall-based handshake with a timeout for device accesses. It also holds a masked interrupt-pending unit that drives `hwint` to CP0. It replaces the fixed two-timer bridge in the CPU top level.

## Interface
- `N_DEV`, 2, number of device windows (1..4)
- `DEV_BASE`, 32'h0000_7F00, base of device 0
- `DEV_STRIDE`, 32'h10, address spacing between device windows
- `DEV_SPAN`, 12, bytes decoded per window (`[base, base+DEV_SPAN)`)
- `DM_LIMIT`, 32'h0000_2FFF, last data-memory byte address
- `IRQ_ACK_ADDR`, 32'h0000_7F40, write-only external-IRQ acknowledge
- `IRQ_MASK_ADDR`, 32'h0000_7F44, read/write interrupt mask
- `TIMEOUT`, 15, maximum WAIT cycles before an access is aborted
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `cpu_addr` in 32, `cpu_wdata` in 32, `cpu_byteen` in 4 (nonzero means write), `cpu_rd` in 1 (load strobe)
- `cpu_rdata` out 32, `cpu_stall` out 1
- `req` in 1: CP0 exception/interrupt entry; suppresses all new writes
- `m_data_addr` out 32, `m_data_wdata` out 32, `m_data_byteen` out 4, `m_data_rdata` in 32: data-memory port
- `dev_addr` out 32 (offset within window), `dev_wdata` out 32
- `dev_we` out N_DEV, `dev_re` out N_DEV: one-cycle start pulses
- `dev_rdata` in 32*N_DEV, `dev_ready` in N_DEV, `dev_irq` in N_DEV (level)
- `ext_irq` in 1: external interrupt pulse
- `hwint` out 6, `bus_err` out 1 (sticky)

## Operation
- Decode priority: device window i, then mask/ack registers, then DM (`addr <= DM_LIMIT`), then unmapped.
- DM path (combinational, no stall):
  - `m_data_addr` and `m_data_wdata` are passthrough.
  - `m_data_byteen = req ? 0 : cpu_byteen` when DM is hit; otherwise 0.
  - `cpu_rdata = m_data_rdata`.
- Unmapped access: `cpu_rdata = 0`, write dropped, no stall, no error.
- Device access FSM, states IDLE, WAIT, DONE:
  - IDLE to WAIT on a device hit with (`cpu_rd`, or `cpu_byteen == 4'b1111` and `!req`).
    - Pulse `dev_re[i]` or `dev_we[i]` for one cycle and latch the index i.
    - `cpu_stall = 1`, count = 0.
  - WAIT, `dev_ready[i] == 1`: capture `dev_rdata[i]` into `rdata_q`, go to DONE.
  - WAIT, count == TIMEOUT: `rdata_q = 0`, set `bus_err`, go to DONE.
  - WAIT, otherwise: count increments. `cpu_stall = 1` throughout WAIT.
  - DONE: `cpu_stall = 0`, `cpu_rdata = rdata_q`, go to IDLE unconditionally.
- Device write with `cpu_byteen` not equal to 1111 and not 0: dropped, `bus_err` set, no stall.
- `req` asserted during WAIT does not abort the in-flight access.
- Mask register: 6 bits, reset 6'h3F.
  - Writable with full-word byteen and `!req`: `mask <= cpu_wdata[5:0]`.
  - Reads return `{26'b0, mask}`.
- External pending bit `pend`:
  - Set on the `ext_irq` rising edge (previous-value register).
  - Cleared by a full-word write to `IRQ_ACK_ADDR`. A set in the same cycle wins.
  - `IRQ_ACK_ADDR` reads return 0.
- `hwint[N_DEV-1:0] = dev_irq & mask[N_DEV-1:0]`; `hwint[N_DEV] = pend & mask[N_DEV]`; all higher bits are 0.
- `bus_err` is cleared only by reset.

## Timing
- Reset values:
  - FSM state IDLE; `cpu_stall` 0; `dev_we` and `dev_re` 0; `rdata_q` 0.
  - `pend` 0; `mask` 6'h3F; `bus_err` 0; `hwint` 0 (given `dev_irq` = 0); edge-detect register 0.
- Reset asserted mid-access: FSM returns to IDLE immediately and the stall drops asynchronously.
- Device access with `dev_ready` tied high: 2 stall cycles (IDLE, WAIT), data in the DONE cycle.
- Worst case: TIMEOUT+2 stall cycles.
- The count register width is `$clog2(TIMEOUT+1)`.
- `hwint` latency:
  - `ext_irq` edge to `hwint` is 1 cycle (registered).
  - `dev_irq` to `hwint` is combinational.
- DM and register paths have zero latency.

## Structure
- `bridge_pkg`: FSM state enum (`BR_IDLE`, `BR_WAIT`, `BR_DONE`), default address constants, `HWINT_W = 6`.
- Sub-module `bridge_access_fsm`:
  - Contains the state, count, latched index, `rdata_q` and the timeout error pulse.
  - The top level does decode, the mask/pending logic and the output muxing.

## Test plan
- Load DM at 0x1000 with `m_data_rdata` = 0xDEADBEEF: `cpu_rdata` = 0xDEADBEEF the same cycle, `cpu_stall` 0.
- Write 0x5 to 0x7F14 (dev1), `dev_ready[1]` high at WAIT:
  - One-cycle `dev_we` = 2'b10, `dev_addr` = 4.
  - Stall for 2 cycles, then DONE.
- Read dev0 with `dev_ready` never asserted:
  - Stall for 17 cycles.
  - `cpu_rdata` = 0 in DONE.
  - `bus_err` = 1 and stays 1.
- Store to DM and to dev0 with `req` = 1: `m_data_byteen` = 0, no `dev_we`, no stall.
- `ext_irq` pulse, then mask write 0x3B:
  - `hwint[2]` = 1 one cycle after the edge.
  - `hwint[2]` = 0 after the mask write.
  - Mask 0x3F restores it; a write to 0x7F40 clears it.
  - An ack coinciding with a new edge keeps `pend` = 1.
- Sheet-byte store (byteen 0001) to 0x7F00: dropped, `bus_err` set, no stall.
